// File: rtl/l1_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l1_l2_arbiter
// Brief    : Round-robin sharing of the L1<->L2 port between I- and D-cache;
//            D writeback and its refill run as one locked transaction.
// Revision : 1.0 - initial release
// ============================================================================
module l1_l2_arbiter #(
    parameter int TAG_W  = 21,
    parameter int IDX_W  = 5,
    parameter int LINE_W = 512
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              read_I_L2,
    input  logic [TAG_W-1:0]  tag_I_L2,
    input  logic [IDX_W-1:0]  index_I_L2,
    output logic              ready_L2_I,
    input  logic              read_D_L2,
    input  logic              write_D_L2,
    input  logic [TAG_W-1:0]  tag_D_L2,
    input  logic [TAG_W-1:0]  write_tag_D_L2,
    input  logic [IDX_W-1:0]  index_D_L2,
    input  logic [LINE_W-1:0] write_data_D_L2,
    output logic              ready_L2_D,
    output logic              read_L1_L2,
    output logic              write_L1_L2,
    output logic [TAG_W-1:0]  tag_L1_L2,
    output logic [IDX_W-1:0]  index_L1_L2,
    output logic [LINE_W-1:0] write_data_L1_L2,
    input  logic              ready_L2_L1,
    input  logic [LINE_W-1:0] read_data_L2_L1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_D_WB = 2'd1,
        ST_D_RD = 2'd2,
        ST_I_RD = 2'd3
    } state_t;

    localparam logic c_RR_I = 1'b0;
    localparam logic c_RR_D = 1'b1;

    state_t              r_state, w_state_nxt;
    logic                r_rr_last, w_rr_last_nxt;
    logic                r_read, w_read_nxt;
    logic                r_write, w_write_nxt;
    logic [TAG_W-1:0]    r_tag, w_tag_nxt;
    logic [IDX_W-1:0]    r_index, w_index_nxt;
    logic [LINE_W-1:0]   r_data, w_data_nxt;
    logic                r_ready_i, w_ready_i_nxt;
    logic                r_ready_d, w_ready_d_nxt;
    logic                w_req_d;
    logic                w_grant_d;
    logic                w_grant_i;

    // The refill line is broadcast to the L1s outside this block.
    logic                w_unused_read_data;
    assign w_unused_read_data = ^read_data_L2_L1;

    assign w_req_d   = read_D_L2 | write_D_L2;
    assign w_grant_d = w_req_d && (!read_I_L2 || (r_rr_last == c_RR_I));
    assign w_grant_i = read_I_L2 && !w_grant_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= ST_IDLE;
            r_rr_last <= c_RR_I;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_tag     <= '0;
            r_index   <= '0;
            r_data    <= '0;
            r_ready_i <= 1'b0;
            r_ready_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_last <= w_rr_last_nxt;
            r_read    <= w_read_nxt;
            r_write   <= w_write_nxt;
            r_tag     <= w_tag_nxt;
            r_index   <= w_index_nxt;
            r_data    <= w_data_nxt;
            r_ready_i <= w_ready_i_nxt;
            r_ready_d <= w_ready_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_last_nxt = r_rr_last;
        w_read_nxt    = r_read;
        w_write_nxt   = r_write;
        w_tag_nxt     = r_tag;
        w_index_nxt   = r_index;
        w_data_nxt    = r_data;
        w_ready_i_nxt = 1'b0;
        w_ready_d_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Requests seen during a ready pulse still belong to the
                // transaction that just finished.
                if (!(r_ready_i || r_ready_d)) begin
                    if (w_grant_d) begin
                        w_rr_last_nxt = c_RR_D;
                        w_index_nxt   = index_D_L2;
                        if (write_D_L2) begin
                            w_state_nxt = ST_D_WB;
                            w_write_nxt = 1'b1;
                            w_tag_nxt   = write_tag_D_L2;
                            w_data_nxt  = write_data_D_L2;
                        end else begin
                            w_state_nxt = ST_D_RD;
                            w_read_nxt  = 1'b1;
                            w_tag_nxt   = tag_D_L2;
                        end
                    end else if (w_grant_i) begin
                        w_rr_last_nxt = c_RR_I;
                        w_state_nxt   = ST_I_RD;
                        w_read_nxt    = 1'b1;
                        w_tag_nxt     = tag_I_L2;
                        w_index_nxt   = index_I_L2;
                    end
                end
            end
            ST_D_WB: begin
                if (ready_L2_L1) begin
                    w_write_nxt = 1'b0;
                    if (read_D_L2) begin
                        // Read is raised one cycle later, giving the idle gap.
                        w_state_nxt = ST_D_RD;
                        w_tag_nxt   = tag_D_L2;
                        w_index_nxt = index_D_L2;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_ready_d_nxt = 1'b1;
                    end
                end
            end
            ST_D_RD: begin
                if (!r_read) begin
                    w_read_nxt = 1'b1;
                end else if (ready_L2_L1) begin
                    w_read_nxt    = 1'b0;
                    w_ready_d_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_I_RD: begin
                if (ready_L2_L1) begin
                    w_read_nxt    = 1'b0;
                    w_ready_i_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready_L2_I       = r_ready_i;
    assign ready_L2_D       = r_ready_d;
    assign read_L1_L2       = r_read;
    assign write_L1_L2      = r_write;
    assign tag_L1_L2        = r_tag;
    assign index_L1_L2      = r_index;
    assign write_data_L1_L2 = r_data;

endmodule
`default_nettype wire

// File: tb/tb_l1_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_l2_arbiter
// Brief    : Scoreboard bench for l1_l2_arbiter with a simple L2 responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_l2_arbiter;

    localparam int TAG_W  = 21;
    localparam int IDX_W  = 5;
    localparam int LINE_W = 512;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_RDYI = 2;
    localparam int K_RDYD = 3;

    typedef struct {
        int                kind;
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [LINE_W-1:0] data;
    } ev_t;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              read_I_L2 = 1'b0;
    logic [TAG_W-1:0]  tag_I_L2 = '0;
    logic [IDX_W-1:0]  index_I_L2 = '0;
    logic              ready_L2_I;
    logic              read_D_L2 = 1'b0;
    logic              write_D_L2 = 1'b0;
    logic [TAG_W-1:0]  tag_D_L2 = '0;
    logic [TAG_W-1:0]  write_tag_D_L2 = '0;
    logic [IDX_W-1:0]  index_D_L2 = '0;
    logic [LINE_W-1:0] write_data_D_L2 = '0;
    logic              ready_L2_D;
    logic              read_L1_L2;
    logic              write_L1_L2;
    logic [TAG_W-1:0]  tag_L1_L2;
    logic [IDX_W-1:0]  index_L1_L2;
    logic [LINE_W-1:0] write_data_L1_L2;
    logic              ready_L2_L1;
    logic [LINE_W-1:0] read_data_L2_L1 = '0;

    logic l2_ready_resp = 1'b0;
    logic spur_ready    = 1'b0;
    int   l2_delay      = 4;
    assign ready_L2_L1 = l2_ready_resp | spur_ready;

    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[$];

    l1_l2_arbiter #(.TAG_W(TAG_W), .IDX_W(IDX_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .nrst(nrst),
        .read_I_L2(read_I_L2), .tag_I_L2(tag_I_L2), .index_I_L2(index_I_L2),
        .ready_L2_I(ready_L2_I),
        .read_D_L2(read_D_L2), .write_D_L2(write_D_L2), .tag_D_L2(tag_D_L2),
        .write_tag_D_L2(write_tag_D_L2), .index_D_L2(index_D_L2),
        .write_data_D_L2(write_data_D_L2), .ready_L2_D(ready_L2_D),
        .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2),
        .tag_L1_L2(tag_L1_L2), .index_L1_L2(index_L1_L2),
        .write_data_L1_L2(write_data_L1_L2),
        .ready_L2_L1(ready_L2_L1), .read_data_L2_L1(read_data_L2_L1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void push(input int k, input logic [TAG_W-1:0] t,
                                 input logic [IDX_W-1:0] i, input logic [LINE_W-1:0] d);
        ev_t e;
        e.kind = k; e.tag = t; e.idx = i; e.data = d;
        exp_q.push_back(e);
    endfunction

    // L2 model: answers each new command after l2_delay cycles.
    initial begin
        bit busy = 0;
        int cnt  = 0;
        forever begin
            @(posedge clk); #1;
            l2_ready_resp = 1'b0;
            if (!nrst) begin
                busy = 0;
            end else begin
                if (!busy && (read_L1_L2 || write_L1_L2)) begin
                    busy = 1; cnt = 0;
                end
                if (busy) begin
                    if (cnt == l2_delay) begin
                        l2_ready_resp = 1'b1; busy = 0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every command start and ready pulse.
    initial begin
        logic             prev_rd = 0, prev_wr = 0;
        logic [TAG_W-1:0] cur_tag = '0;
        logic [IDX_W-1:0] cur_idx = '0;
        ev_t e;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prev_rd = 0; prev_wr = 0;
            end else begin
                if (read_L1_L2 && write_L1_L2) chk("rw_exclusive", 1, 0);
                if ((prev_rd && write_L1_L2) || (prev_wr && read_L1_L2)) chk("cmd_gap", 1, 0);
                if ((read_L1_L2 && !prev_rd) || (write_L1_L2 && !prev_wr)) begin
                    if (exp_q.size() == 0) chk("unexpected_cmd", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("cmd_kind", write_L1_L2 ? K_WR : K_RD, e.kind);
                        chk("cmd_tag", tag_L1_L2, e.tag);
                        chk("cmd_idx", index_L1_L2, e.idx);
                        if (write_L1_L2) chk("cmd_data", write_data_L1_L2, e.data);
                    end
                    cur_tag = tag_L1_L2; cur_idx = index_L1_L2;
                end
                if (ready_L2_L1 && (read_L1_L2 || write_L1_L2)) begin
                    chk("hold_tag", tag_L1_L2, cur_tag);
                    chk("hold_idx", index_L1_L2, cur_idx);
                end
                if (ready_L2_I) begin
                    if (exp_q.size() == 0) chk("unexpected_rdy_i", 1, 0);
                    else begin e = exp_q.pop_front(); chk("rdy_i_kind", K_RDYI, e.kind); end
                end
                if (ready_L2_D) begin
                    if (exp_q.size() == 0) chk("unexpected_rdy_d", 1, 0);
                    else begin e = exp_q.pop_front(); chk("rdy_d_kind", K_RDYD, e.kind); end
                end
                prev_rd = read_L1_L2; prev_wr = write_L1_L2;
            end
        end
    end

    task automatic wait_pulse(input bit is_d, input string nm);
        bit seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if ((!is_d && ready_L2_I) || (is_d && ready_L2_D)) begin seen = 1; break; end
        end
        if (!seen) chk({"timeout_", nm}, 0, 1);
    endtask

    task automatic set_d(input bit rd, input bit wr, input logic [TAG_W-1:0] t,
                         input logic [TAG_W-1:0] wt, input logic [IDX_W-1:0] i,
                         input logic [LINE_W-1:0] d);
        read_D_L2 = rd; write_D_L2 = wr; tag_D_L2 = t;
        write_tag_D_L2 = wt; index_D_L2 = i; write_data_D_L2 = d;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_read"}, read_L1_L2, 0);
        chk({nm, "_write"}, write_L1_L2, 0);
        chk({nm, "_rdy_i"}, ready_L2_I, 0);
        chk({nm, "_rdy_d"}, ready_L2_D, 0);
    endtask

    initial begin
        logic [LINE_W-1:0] dat_a, dat_b;
        bit seen;
        dat_a = {16{32'hDEADBEEF}};
        dat_b = {16{32'h0BADF00D}};

        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        chk_idle_outputs("reset");
        chk("reset_tag", tag_L1_L2, 0);
        chk("reset_idx", index_L1_L2, 0);
        chk("reset_data", write_data_L1_L2, 0);

        // Tie after reset: D first, then I; second tie again D first.
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            push(K_RD, 21'h00022, 5'd4, '0); push(K_RDYD, '0, '0, '0);
            push(K_RD, 21'h00011, 5'd2, '0); push(K_RDYI, '0, '0, '0);
            read_I_L2 = 1; tag_I_L2 = 21'h00011; index_I_L2 = 5'd2;
            set_d(1, 0, 21'h00022, 21'h0, 5'd4, '0);
            wait_pulse(1, "tie_d"); set_d(0, 0, '0, '0, '0, '0);
            wait_pulse(0, "tie_i"); read_I_L2 = 0;
        end

        // I-only refill.
        @(posedge clk); #1;
        push(K_RD, 21'h00ABC, 5'd3, '0); push(K_RDYI, '0, '0, '0);
        read_I_L2 = 1; tag_I_L2 = 21'h00ABC; index_I_L2 = 5'd3;
        wait_pulse(0, "i_only"); read_I_L2 = 0;

        // I refill with inputs changed mid-transaction.
        @(posedge clk); #1;
        push(K_RD, 21'h12345, 5'd9, '0); push(K_RDYI, '0, '0, '0);
        read_I_L2 = 1; tag_I_L2 = 21'h12345; index_I_L2 = 5'd9;
        repeat (2) @(posedge clk);
        #1 tag_I_L2 = 21'h1FFFF; index_I_L2 = 5'd1;
        wait_pulse(0, "i_hold"); read_I_L2 = 0;

        // D writeback followed by refill.
        @(posedge clk); #1;
        push(K_WR, 21'h00001, 5'd7, dat_a); push(K_RD, 21'h00002, 5'd7, '0);
        push(K_RDYD, '0, '0, '0);
        set_d(1, 1, 21'h00002, 21'h00001, 5'd7, dat_a);
        wait_pulse(1, "d_wb_rd"); set_d(0, 0, '0, '0, '0, '0);

        // D clean refill.
        @(posedge clk); #1;
        push(K_RD, 21'h0F0F0, 5'd31, '0); push(K_RDYD, '0, '0, '0);
        set_d(1, 0, 21'h0F0F0, 21'h1AAAA, 5'd31, dat_b);
        wait_pulse(1, "d_clean"); set_d(0, 0, '0, '0, '0, '0);

        // D writeback without refill.
        @(posedge clk); #1;
        push(K_WR, 21'h15555, 5'd12, dat_b); push(K_RDYD, '0, '0, '0);
        set_d(0, 1, 21'h0, 21'h15555, 5'd12, dat_b);
        wait_pulse(1, "d_wb_only"); set_d(0, 0, '0, '0, '0, '0);

        // Spurious L2 ready while idle.
        repeat (2) @(posedge clk);
        #1 spur_ready = 1;
        @(posedge clk); #1 spur_ready = 0;
        for (int k = 0; k < 3; k++) begin
            chk_idle_outputs("spurious");
            @(posedge clk); #1;
        end

        // Reset during writeback, then a clean refill proves restart.
        l2_delay = 20;
        push(K_WR, 21'h0CAFE, 5'd5, dat_a);
        set_d(1, 1, 21'h0BEEF, 21'h0CAFE, 5'd5, dat_a);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (write_L1_L2) begin seen = 1; break; end
        end
        if (!seen) chk("timeout_wb_start", 0, 1);
        @(posedge clk); #2 nrst = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        chk("async_rst_tag", tag_L1_L2, 0);
        chk("async_rst_idx", index_L1_L2, 0);
        chk("async_rst_data", write_data_L1_L2, 0);
        set_d(0, 0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        l2_delay = 4;
        @(posedge clk); #1;
        push(K_RD, 21'h00777, 5'd6, '0); push(K_RDYD, '0, '0, '0);
        set_d(1, 0, 21'h00777, 21'h0, 5'd6, '0);
        wait_pulse(1, "after_rst"); set_d(0, 0, '0, '0, '0, '0);

        repeat (5) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
